// File: rtl/activity_4_serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings and default width.
package activity_4_serial_subtractor_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

endpackage

// File: rtl/activity_4_serial_subtractor_if.sv
// Start/done handshake bundle between a controller (master) and the serial subtractor (slave).
interface activity_4_serial_subtractor_if
    import activity_4_serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output start, a, b,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, bout
    );

endinterface

// File: rtl/activity_4_full_subtractor.sv
// One-bit combinational full subtractor: d = a - b - bin, with borrow out.
module activity_4_full_subtractor (
    input  logic i_a,
    input  logic i_b,
    input  logic i_bin,
    output logic o_bout,
    output logic o_d
);

    always_comb begin
        o_d    = i_a ^ i_b ^ i_bin;
        o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);
    end

endmodule

// File: rtl/activity_4_serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock through a single full-subtractor cell.
module activity_4_serial_subtractor
    import activity_4_serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    activity_4_serial_subtractor_if.slave bus
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    state_e           r_state;
    state_e           w_state_d;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res;
    logic             r_br;
    logic [CntW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;

    logic             w_d;
    logic             w_br_n;
    logic             w_last;
    logic [WIDTH-1:0] w_res_nxt;

    activity_4_full_subtractor u_fs (
        .i_a    (r_a_sh[0]),
        .i_b    (r_b_sh[0]),
        .i_bin  (r_br),
        .o_bout (w_br_n),
        .o_d    (w_d)
    );

    always_comb begin
        w_last    = (r_cnt == CntW'(WIDTH - 1));
        // New bit enters at the MSB so the first (LSB) bit ends up in bit 0.
        w_res_nxt = {w_d, r_res[WIDTH-1:1]};
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (bus.start) w_state_d = StShift;
            StShift: if (w_last) w_state_d = StDone;
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a_sh <= '0;
            r_b_sh <= '0;
            r_res  <= '0;
            r_br   <= 1'b0;
            r_cnt  <= '0;
            r_diff <= '0;
            r_bout <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        r_a_sh <= bus.a;
                        r_b_sh <= bus.b;
                        r_res  <= '0;
                        r_br   <= 1'b0;
                        r_cnt  <= '0;
                    end
                end
                StShift: begin
                    r_a_sh <= r_a_sh >> 1;
                    r_b_sh <= r_b_sh >> 1;
                    r_res  <= w_res_nxt;
                    r_br   <= w_br_n;
                    r_cnt  <= r_cnt + CntW'(1);
                    if (w_last) begin
                        r_diff <= w_res_nxt;
                        r_bout <= w_br_n;
                    end
                end
                StDone: begin
                    r_cnt <= '0;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        bus.busy = (r_state == StShift);
        bus.done = (r_state == StDone);
        bus.diff = r_diff;
        bus.bout = r_bout;
    end

endmodule

// File: tb/tb_activity_4_serial_subtractor.sv
// Scoreboard bench: stimulus pushes expected results, a negedge monitor pops them on each done.
module tb_activity_4_serial_subtractor;
    import activity_4_serial_subtractor_pkg::*;

    localparam int unsigned W = 8;

    typedef struct packed {
        logic [W-1:0] d;
        logic         b;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    activity_4_serial_subtractor_if #(.WIDTH(W)) bus ();

    activity_4_serial_subtractor #(.WIDTH(W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    exp_t         q[$];
    exp_t         m_exp;
    int           checks = 0;
    int           failures = 0;
    int           n_exp = 0;
    int           n_done = 0;
    int           busy_run = 0;
    bit           stab_en = 1'b0;
    logic [W-1:0] prev_diff = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: event not seen within bound at %0t", name, $time);
    endtask

    // Monitor: pops one expected result per done pulse, also checks busy run length.
    always @(negedge clk) begin
        check("busy_done_exclusive", {31'd0, bus.busy & bus.done}, 32'd0);
        if (bus.done) begin
            n_done++;
            check("busy_len", busy_run, W);
            if (q.size() == 0) begin
                fail_now("unexpected_done");
            end else begin
                m_exp = q.pop_front();
                check("diff", {24'd0, bus.diff}, {24'd0, m_exp.d});
                check("bout", {31'd0, bus.bout}, {31'd0, m_exp.b});
            end
        end
        if (stab_en && !bus.done) check("diff_stable", {24'd0, bus.diff}, {24'd0, prev_diff});
        prev_diff = bus.diff;
        if (bus.busy) busy_run++;
        else busy_run = 0;
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] d, input logic bo, input bit push);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        if (push) begin
            q.push_back({d, bo});
            n_exp++;
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!bus.done && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!bus.done) fail_now("done_timeout");
    endtask

    task automatic wait_busy_rise();
        int n = 0;
        while (bus.busy && n < 30) begin
            @(negedge clk);
            n++;
        end
        while (!bus.busy && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!bus.busy) fail_now("busy_timeout");
    endtask

    initial begin
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        #1;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_diff", {24'd0, bus.diff}, 32'd0);
        check("rst_bout", {31'd0, bus.bout}, 32'd0);
        #22 rst_n = 1'b1;

        issue(8'h5A, 8'h23, 8'h37, 1'b0, 1'b1); wait_done();
        issue(8'h10, 8'h20, 8'hF0, 1'b1, 1'b1); wait_done();
        issue(8'hFF, 8'h01, 8'hFE, 1'b0, 1'b1); wait_done();
        issue(8'h00, 8'h00, 8'h00, 1'b0, 1'b1); wait_done();
        issue(8'h00, 8'hFF, 8'h01, 1'b1, 1'b1); wait_done();

        // A start during SHIFT must be ignored: one result, no second done.
        issue(8'h5A, 8'h23, 8'h37, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h01;
        bus.b     = 8'h02;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();
        repeat (15) @(negedge clk);

        // start held high: back-to-back operations, operands swapped after each accept.
        @(negedge clk);
        bus.a     = 8'h30;
        bus.b     = 8'h10;
        bus.start = 1'b1;
        q.push_back({8'h20, 1'b0});
        n_exp++;
        stab_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_busy_rise();
            if (k == 0) begin
                bus.a = 8'h05;
                bus.b = 8'h07;
                q.push_back({8'hFE, 1'b1});
                n_exp++;
            end else if (k == 1) begin
                bus.a = 8'h80;
                bus.b = 8'h7F;
                q.push_back({8'h01, 1'b0});
                n_exp++;
            end else begin
                bus.start = 1'b0;
            end
        end
        wait_done();
        @(negedge clk);
        stab_en = 1'b0;

        // Asynchronous reset mid-SHIFT, between clock edges.
        issue(8'h5A, 8'h23, 8'h00, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, bus.busy}, 32'd0);
        check("arst_done", {31'd0, bus.done}, 32'd0);
        check("arst_diff", {24'd0, bus.diff}, 32'd0);
        check("arst_bout", {31'd0, bus.bout}, 32'd0);
        #1 rst_n = 1'b1;
        repeat (15) @(negedge clk);
        issue(8'h5A, 8'h23, 8'h37, 1'b0, 1'b1); wait_done();

        repeat (5) @(negedge clk);
        check("done_count", n_done, n_exp);
        check("queue_empty", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
